// File: rtl/cpu_bus_arbiter.sv
// Two-master round-robin arbiter merging the CPU instruction and data buses
// onto one WaitRequest-style memory bus; grants switch only at transfer boundaries.
module cpu_bus_arbiter #(
  parameter int ADDR_W      = 30,
  parameter bit RESET_GRANT = 1'b0
) (
  input  logic              i_Clk,
  input  logic              i_Rst_n,
  input  logic [ADDR_W-1:0] i_IBus_Address,
  input  logic              i_IBus_Read,
  output logic [31:0]       o_IBus_ReadData,
  output logic              o_IBus_WaitReq,
  input  logic [ADDR_W-1:0] i_DBus_Address,
  input  logic [3:0]        i_DBus_ByteEn,
  input  logic              i_DBus_Read,
  input  logic              i_DBus_Write,
  input  logic [31:0]       i_DBus_WriteData,
  output logic [31:0]       o_DBus_ReadData,
  output logic              o_DBus_WaitRequest,
  output logic [ADDR_W-1:0] o_Mem_Address,
  output logic [3:0]        o_Mem_ByteEn,
  output logic              o_Mem_Read,
  output logic              o_Mem_Write,
  output logic [31:0]       o_Mem_WriteData,
  input  logic [31:0]       i_Mem_ReadData,
  input  logic              i_Mem_WaitRequest
);

  typedef enum logic {
    GNT_IBUS = 1'b0,
    GNT_DBUS = 1'b1
  } grant_t;

  grant_t r_Grant;

  logic iReq;
  logic dReq;
  logic gReq;
  logic oReq;
  logic muxRead;
  logic muxWrite;

  assign iReq = i_IBus_Read;
  assign dReq = i_DBus_Read | i_DBus_Write;

  always_comb begin
    gReq = 1'b0;
    oReq = 1'b0;
    unique case (r_Grant)
      GNT_IBUS: begin
        gReq = iReq;
        oReq = dReq;
      end
      GNT_DBUS: begin
        gReq = dReq;
        oReq = iReq;
      end
    endcase
  end

  // Hold while the owner is stalled; otherwise hand over whenever the
  // other master is waiting, else park on the current owner.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Grant <= grant_t'(RESET_GRANT);
    end else if (!(gReq & i_Mem_WaitRequest) & oReq) begin
      r_Grant <= (r_Grant == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;
    end
  end

  always_comb begin
    o_Mem_Address   = '0;
    o_Mem_ByteEn    = 4'h0;
    o_Mem_WriteData = 32'h0;
    muxRead         = 1'b0;
    muxWrite        = 1'b0;
    unique case (r_Grant)
      GNT_IBUS: begin
        o_Mem_Address = i_IBus_Address;
        o_Mem_ByteEn  = 4'hF;
        muxRead       = iReq;
      end
      GNT_DBUS: begin
        o_Mem_Address   = i_DBus_Address;
        o_Mem_ByteEn    = i_DBus_ByteEn;
        o_Mem_WriteData = i_DBus_WriteData;
        muxRead         = i_DBus_Read & ~i_DBus_Write;
        muxWrite        = i_DBus_Write;
      end
    endcase
  end

  // Strobes drop immediately on reset, not at the next edge.
  assign o_Mem_Read  = muxRead & i_Rst_n;
  assign o_Mem_Write = muxWrite & i_Rst_n;

  assign o_IBus_WaitReq     = (r_Grant != GNT_IBUS) | i_Mem_WaitRequest;
  assign o_DBus_WaitRequest = (r_Grant != GNT_DBUS) | i_Mem_WaitRequest;

  assign o_IBus_ReadData = i_Mem_ReadData;
  assign o_DBus_ReadData = i_Mem_ReadData;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios then random
// traffic, all checked against a behavioural owner-tracking model.
module tb_cpu_bus_arbiter;

  localparam int AW = 30;
  localparam bit RG = 1'b0;

  logic          clk = 1'b0;
  logic          rstN;
  logic [AW-1:0] iAddr;
  logic          iRd;
  logic [31:0]   iRData;
  logic          iWait;
  logic [AW-1:0] dAddr;
  logic [3:0]    dBe;
  logic          dRd;
  logic          dWr;
  logic [31:0]   dWData;
  logic [31:0]   dRData;
  logic          dWait;
  logic [AW-1:0] mAddr;
  logic [3:0]    mBe;
  logic          mRd;
  logic          mWr;
  logic [31:0]   mWData;
  logic [31:0]   mRData;
  logic          mWait;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // owner of the bus in the model: 0 = instruction side, 1 = data side
  int own;
  int iDone;
  int dDone;
  int lastAcc;

  always #5 clk = ~clk;

  cpu_bus_arbiter #(.ADDR_W(AW), .RESET_GRANT(RG)) dut (
    .i_Clk             (clk),
    .i_Rst_n           (rstN),
    .i_IBus_Address    (iAddr),
    .i_IBus_Read       (iRd),
    .o_IBus_ReadData   (iRData),
    .o_IBus_WaitReq    (iWait),
    .i_DBus_Address    (dAddr),
    .i_DBus_ByteEn     (dBe),
    .i_DBus_Read       (dRd),
    .i_DBus_Write      (dWr),
    .i_DBus_WriteData  (dWData),
    .o_DBus_ReadData   (dRData),
    .o_DBus_WaitRequest(dWait),
    .o_Mem_Address     (mAddr),
    .o_Mem_ByteEn      (mBe),
    .o_Mem_Read        (mRd),
    .o_Mem_Write       (mWr),
    .o_Mem_WriteData   (mWData),
    .i_Mem_ReadData    (mRData),
    .i_Mem_WaitRequest (mWait)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all outputs against the model, then advance one clock.
  task automatic step(input string tag);
    int w;
    bit ir;
    bit dr;
    bit gReq;
    bit oReq;
    #1;
    if (!rstN) own = int'(RG);
    ir = iRd;
    dr = dRd || dWr;
    chk({tag, ":iWait"}, 64'(iWait), 64'(own != 0 || mWait));
    chk({tag, ":dWait"}, 64'(dWait), 64'(own != 1 || mWait));
    chk({tag, ":iRData"}, 64'(iRData), 64'(mRData));
    chk({tag, ":dRData"}, 64'(dRData), 64'(mRData));
    if (own == 0) begin
      chk({tag, ":mAddr"}, 64'(mAddr), 64'(iAddr));
      chk({tag, ":mBe"}, 64'(mBe), 64'hF);
      chk({tag, ":mRd"}, 64'(mRd), 64'(rstN && ir));
      chk({tag, ":mWr"}, 64'(mWr), 64'(0));
      chk({tag, ":mWData"}, 64'(mWData), 64'(0));
    end else begin
      chk({tag, ":mAddr"}, 64'(mAddr), 64'(dAddr));
      chk({tag, ":mBe"}, 64'(mBe), 64'(dBe));
      chk({tag, ":mRd"}, 64'(mRd), 64'(rstN && dRd && !dWr));
      chk({tag, ":mWr"}, 64'(mWr), 64'(rstN && dWr));
      chk({tag, ":mWData"}, 64'(mWData), 64'(dWData));
    end
    // count acceptances as seen on the DUT's own handshake
    if (rstN && ir && !iWait) begin
      iDone++;
      lastAcc = 0;
    end
    if (rstN && dr && !dWait) begin
      dDone++;
      lastAcc = 1;
    end
    @(posedge clk);
    w = own;
    gReq = (w == 0) ? ir : dr;
    oReq = (w == 0) ? dr : ir;
    if (!rstN) own = int'(RG);
    else if (!(gReq && mWait) && oReq) own = 1 - w;
    @(negedge clk);
  endtask

  task automatic idle();
    iRd = 0;
    dRd = 0;
    dWr = 0;
    mWait = 0;
  endtask

  initial begin
    int prev;
    int n;
    bit alt;
    own = int'(RG);
    iDone = 0;
    dDone = 0;
    lastAcc = -1;
    rstN = 0;
    iAddr = '0;
    dAddr = '0;
    dBe = 4'h0;
    dWData = '0;
    mRData = 32'hA5A5A5A5;
    idle();
    @(negedge clk);

    // reset release with instruction read pending at 0x10
    iRd = 1;
    iAddr = 30'h10;
    step("rst");
    rstN = 1;
    step("ifirst");
    iRd = 0;

    // data write while parked on instruction side
    dWr = 1;
    dAddr = 30'h20;
    dBe = 4'b0011;
    dWData = 32'h1234;
    step("dsw");
    step("dwr");
    dWr = 0;

    // instruction read stalled by memory while data waits
    iRd = 1;
    iAddr = 30'h44;
    step("iget");
    dRd = 1;
    dAddr = 30'h88;
    mWait = 1;
    repeat (3) step("istall");
    mWait = 0;
    step("iacc");
    iRd = 0;
    step("dafter");
    idle();
    step("park");

    // continuous contention, zero-wait memory
    iRd = 1;
    dRd = 1;
    iDone = 0;
    dDone = 0;
    n = 0;
    prev = -1;
    alt = 1;
    for (int k = 0; k < 24 && (iDone + dDone) < 8; k++) begin
      if (k == 0) step("cont0");
      else step("cont");
      if (lastAcc != prev) prev = lastAcc;
      else if (iDone + dDone != n) alt = 0;
      n = iDone + dDone;
    end
    chk("cont_total", 64'(iDone + dDone), 64'(8));
    chk("cont_i", 64'(iDone), 64'(4));
    chk("cont_d", 64'(dDone), 64'(4));
    chk("cont_alt", 64'(alt), 64'(1));
    idle();

    // data read and write asserted together
    dRd = 1;
    dWr = 1;
    dWData = 32'hCAFEF00D;
    step("rw0");
    step("rw1");
    chk("rw_wr", 64'(mWr), 64'(1));
    chk("rw_rd", 64'(mRd), 64'(0));

    // reset mid-stall while data side owns the bus
    dRd = 0;
    mWait = 1;
    step("stall");
    rstN = 0;
    #2;
    chk("rst_wr_drop", 64'(mWr), 64'(0));
    step("inrst");
    rstN = 1;
    idle();
    step("postrst");

    // random traffic
    for (int k = 0; k < 400; k++) begin
      rstN = ($urandom_range(0, 49) != 0);
      iRd = $urandom_range(0, 1);
      dRd = $urandom_range(0, 1);
      dWr = $urandom_range(0, 2) == 0;
      mWait = $urandom_range(0, 2) == 0;
      iAddr = AW'($urandom);
      dAddr = AW'($urandom);
      dBe = 4'($urandom);
      dWData = $urandom;
      mRData = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
